// File: rtl/gecko_mem_responder_if.sv
// std_mem_intf: valid/ready memory request and result bundle.
// The responder takes modport in for requests and modport out for results.
interface std_mem_intf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH/8-1:0] write_enable;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;

  modport in (
    input  valid,
    input  write_enable,
    input  addr,
    input  data,
    output ready
  );

  modport out (
    output valid,
    output data,
    input  ready
  );
endinterface

// File: rtl/gecko_mem_responder.sv
// Word RAM target for std_mem_intf: read-before-write, fixed latency,
// credit-protected result FIFO so results are never dropped.
module gecko_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 1,
  parameter int RESULT_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  std_mem_intf.in  mem_in,
  std_mem_intf.out mem_out
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = (NB > 1) ? $clog2(NB) : 0;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CW   = $clog2(RESULT_DEPTH + 1);
  localparam int NS   = (LATENCY > 1) ? LATENCY - 1 : 1;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $fatal(1, "DATA_WIDTH must be a multiple of 8");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_lat
    $fatal(1, "LATENCY must be in 1..4");
  end
  if (RESULT_DEPTH < LATENCY + 1) begin : g_bad_rd
    $fatal(1, "RESULT_DEPTH must be >= LATENCY + 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two");
  end
  if (OFFW + IW > ADDR_WIDTH) begin : g_bad_aw
    $fatal(1, "ADDR_WIDTH too narrow for DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  acc;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_addr;

  assign acc         = mem_in.valid && mem_in.ready;
  assign idx         = mem_in.addr[OFFW +: IW];
  assign rdata       = mem_q[idx];
  assign unused_addr = ^mem_in.addr;

  // Result data is the pre-write word: read is combinational off mem_q.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_in.write_enable[i]) begin
          mem_q[idx][8*i +: 8] <= mem_in.data[8*i +: 8];
        end
      end
    end
  end

  logic [NS-1:0]         pv_q;
  logic [DATA_WIDTH-1:0] pd_q [NS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= acc;
      for (int i = 1; i < NS; i++) begin
        pv_q[i] <= pv_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pd_q[0] <= rdata;
    for (int i = 1; i < NS; i++) begin
      pd_q[i] <= pd_q[i-1];
    end
  end

  // The FIFO write itself is the last latency register.
  logic                  push_v;
  logic [DATA_WIDTH-1:0] push_d;

  assign push_v = (LATENCY == 1) ? acc   : pv_q[NS-1];
  assign push_d = (LATENCY == 1) ? rdata : pd_q[NS-1];

  logic [DATA_WIDTH-1:0] fifo_q [RESULT_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         fcnt_q, fcnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  pop;

  assign pop = mem_out.valid && mem_out.ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fcnt_d  = fcnt_q;
    outst_d = outst_q;
    if (push_v) begin
      wptr_d = (wptr_q == PW'(RESULT_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(RESULT_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    unique case ({push_v, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    unique case ({acc, pop})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
      outst_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fcnt_q  <= fcnt_d;
      outst_q <= outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_v) begin
      fifo_q[wptr_q] <= push_d;
    end
  end

  assign mem_out.valid = (fcnt_q != '0);
  assign mem_out.data  = fifo_q[rptr_q];
  assign mem_in.ready  = (outst_q < CW'(RESULT_DEPTH));

  a_outst_bound: assert property (
    @(posedge clk) disable iff (rst) outst_q <= CW'(RESULT_DEPTH));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push_v && !pop && fcnt_q == CW'(RESULT_DEPTH)));

endmodule

// File: tb/tb_gecko_mem_responder.sv
// Directed bench for gecko_mem_responder at LATENCY 1 and 2.
// Both instances see the same request stream and result ready.
module tb_gecko_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int RD    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  int nacc = 0;

  logic        req_v    = 1'b0;
  logic [3:0]  req_we   = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        rdy_out  = 1'b1;
  bit          chk_lat  = 1'b0;
  bit          strm     = 1'b0;
  bit          init_ph  = 1'b0;

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          dc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] ref_mem [DEPTH];

  std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) in1 ();
  std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out1 ();
  std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) in2 ();
  std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out2 ();

  logic both_rdy;
  assign both_rdy = in1.ready && in2.ready;

  assign in1.valid         = req_v && both_rdy;
  assign in1.write_enable  = req_we;
  assign in1.addr          = req_addr;
  assign in1.data          = req_data;
  assign in2.valid         = req_v && both_rdy;
  assign in2.write_enable  = req_we;
  assign in2.addr          = req_addr;
  assign in2.data          = req_data;
  assign out1.ready        = rdy_out;
  assign out1.write_enable = '0;
  assign out1.addr         = '0;
  assign out2.ready        = rdy_out;
  assign out2.write_enable = '0;
  assign out2.addr         = '0;

  gecko_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .LATENCY(1), .RESULT_DEPTH(RD)
  ) u_l1 (
    .clk(clk), .rst(rst), .mem_in(in1), .mem_out(out1)
  );

  gecko_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .LATENCY(2), .RESULT_DEPTH(RD)
  ) u_l2 (
    .clk(clk), .rst(rst), .mem_in(in2), .mem_out(out2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %08h want %08h @%0t", tag, got, want, $time);
    end
  endtask

  exp_t        e1, e2;
  logic [31:0] hold1, hold2;
  bit          hv1 = 1'b0;
  bit          hv2 = 1'b0;

  always @(negedge clk) begin
    if (!rst && out1.valid) begin
      if (q1.size() == 0) begin
        check("l1_spurious", 32'd1, 32'd0);
      end else if (rdy_out) begin
        e1 = q1.pop_front();
        if (!e1.dc) check("l1_data", out1.data, e1.d);
        if (chk_lat) check("l1_lat", cyc - e1.c, 32'd1);
      end else if (hv1) begin
        check("l1_hold", out1.data, hold1);
      end
    end
    if (!rst && strm) check("l1_occ", 32'(q1.size() <= RD), 32'd1);
    hv1   = !rst && out1.valid && !rdy_out;
    hold1 = out1.data;
  end

  always @(negedge clk) begin
    if (!rst && out2.valid) begin
      if (q2.size() == 0) begin
        check("l2_spurious", 32'd1, 32'd0);
      end else if (rdy_out) begin
        e2 = q2.pop_front();
        if (!e2.dc) check("l2_data", out2.data, e2.d);
        if (chk_lat) check("l2_lat", cyc - e2.c, 32'd2);
      end else if (hv2) begin
        check("l2_hold", out2.data, hold2);
      end
    end
    if (!rst && strm) check("l2_occ", 32'(q2.size() <= RD), 32'd1);
    hv2   = !rst && out2.valid && !rdy_out;
    hold2 = out2.data;
  end

  // Presents one request until both instances accept it.
  task automatic issue(input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] d, input bit use_ref,
                       input logic [31:0] ex, output int waited);
    logic [5:0]  w;
    bit          ok;
    exp_t        e;
    req_v    = 1'b1;
    req_we   = we;
    req_addr = a;
    req_data = d;
    waited   = 0;
    ok       = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ok = both_rdy;
      if (ok) begin
        w    = a[7:2];
        e.d  = use_ref ? ref_mem[w] : ex;
        e.c  = cyc;
        e.dc = init_ph;
        q1.push_back(e);
        q2.push_back(e);
        for (int i = 0; i < 4; i++) begin
          if (we[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
        end
        nacc++;
      end
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
    end
    if (!ok) begin
      check("issue_timeout", 32'd0, 32'd1);
      req_v = 1'b0;
    end
  endtask

  task automatic idle();
    req_v  = 1'b0;
    req_we = '0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      check("drain_timeout", 32'd0, 32'd1);
      q1.delete();
      q2.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wt;
    #1;
    check("rst_valid_l1", 32'(out1.valid), 32'd0);
    check("rst_valid_l2", 32'(out2.valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready_l1", 32'(in1.ready), 32'd1);
    check("rst_ready_l2", 32'(in2.ready), 32'd1);

    init_ph = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      issue(4'hF, 32'(i * 4), 32'h0, 1'b0, 32'h0, wt);
    end
    init_ph = 1'b0;
    idle();
    drain();

    chk_lat = 1'b1;
    issue(4'h0, 32'h0, 32'h0, 1'b0, 32'h0000_0000, wt);
    idle();
    @(negedge clk);
    check("idle_ready_l1", 32'(in1.ready), 32'd1);
    check("idle_ready_l2", 32'(in2.ready), 32'd1);
    drain();

    issue(4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, wt);
    issue(4'h0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF, wt);
    issue(4'h1, 32'h10, 32'h0000_00AA, 1'b0, 32'hDEAD_BEEF, wt);
    issue(4'h0, 32'h12, 32'h0,         1'b0, 32'hDEAD_BEAA, wt);
    issue(4'h0, 32'h10 + 32'(4 * DEPTH), 32'h0, 1'b0, 32'hDEAD_BEAA, wt);
    idle();
    drain();
    chk_lat = 1'b0;

    rdy_out = 1'b0;
    nacc    = 0;
    fork
      begin
        issue(4'h0, 32'h00, 32'h0, 1'b0, 32'h0000_0000, wt);
        issue(4'h0, 32'h04, 32'h0, 1'b0, 32'h0000_0000, wt);
        issue(4'h0, 32'h08, 32'h0, 1'b0, 32'h0000_0000, wt);
        issue(4'h0, 32'h0C, 32'h0, 1'b0, 32'h0000_0000, wt);
        issue(4'h0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEAA, wt);
        issue(4'h0, 32'h14, 32'h0, 1'b0, 32'h0000_0000, wt);
        idle();
      end
      begin
        repeat (10) @(negedge clk);
        check("bp_accepted", 32'(nacc), 32'd4);
        check("bp_full_l1", 32'(in1.ready), 32'd0);
        check("bp_full_l2", 32'(in2.ready), 32'd0);
        @(posedge clk);
        #1;
        rdy_out = 1'b1;
        @(negedge clk);
        check("bp_rdy_reg_l1", 32'(in1.ready), 32'd0);
        check("bp_rdy_reg_l2", 32'(in2.ready), 32'd0);
      end
    join
    drain();
    check("bp_total", 32'(nacc), 32'd6);

    chk_lat = 1'b1;
    strm    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [3:0]  we;
      logic [31:0] a;
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      a  = 32'h20 + 32'($urandom_range(0, 31));
      issue(we, a, $urandom, 1'b1, 32'h0, wt);
      check("strm_nowait", 32'(wt), 32'd0);
    end
    idle();
    drain();
    strm    = 1'b0;
    chk_lat = 1'b0;

    rdy_out = 1'b0;
    issue(4'hF, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, wt);
    issue(4'h0, 32'h00, 32'h0, 1'b0, 32'h0, wt);
    issue(4'h0, 32'h04, 32'h0, 1'b0, 32'h0, wt);
    idle();
    @(posedge clk);
    @(negedge clk);
    #2;
    q1.delete();
    q2.delete();
    rst = 1'b1;
    #1;
    check("arst_valid_l1", 32'(out1.valid), 32'd0);
    check("arst_valid_l2", 32'(out2.valid), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst     = 1'b0;
    rdy_out = 1'b1;
    check("arst_ready_l1", 32'(in1.ready), 32'd1);
    check("arst_ready_l2", 32'(in2.ready), 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    issue(4'h0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF, wt);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
